sram_bridge: RTL and testbench

- Downstream stage between the z80computer memory bus (addr/dat/we/cs/ack) and the external asynchronous SRAM (18-bit address, 8-bit bidirectional data).
- Replaces direct combinational SRAM strobing with a registered access sequencer.
- Provides programmable wait states, clean write-enable timing, registered read data and a 16 KiB bank window that reaches the full 256 KiB SRAM.
- The tristate pad itself stays in top; this block only drives the output value and the output-enable.

---
 rtl/sram_bridge.sv | 129 ++++++++++++
 tb/tb_sram_bridge.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sram_bridge.sv
// sram_bridge: registered access sequencer from the CPU memory bus to a banked async SRAM.
module sram_bridge #(
   parameter int WAIT_CYCLES = 1,
   parameter int BANK_BITS   = 4
) (
   input  logic                 i_clk,
   input  logic                 i_reset_n,
   input  logic [15:0]          i_addr,
   input  logic [7:0]           i_dat,
   output logic [7:0]           o_dat,
   input  logic                 i_we,
   input  logic                 i_cs,
   output logic                 o_ack,
   input  logic                 i_bank_we,
   input  logic [BANK_BITS-1:0] i_bank,
   output logic [BANK_BITS-1:0] o_bank,
   output logic [17:0]          o_sram_addr,
   output logic [7:0]           o_sram_dat,
   output logic                 o_sram_dat_oe,
   input  logic [7:0]           i_sram_dat,
   output logic                 o_sram_cs_n,
   output logic                 o_sram_oe_n,
   output logic                 o_sram_we_n
);
   typedef enum logic [2:0] {IDLE, SETUP, ACCESS, ACK, RELEASE} state_t;
   state_t                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic                   we_q, we_d;
   logic                   ack_q, ack_d;
   logic [7:0]             dat_q, dat_d;
   logic [7:0]             wdat_q, wdat_d;
   logic [BANK_BITS-1:0]   bank_q, bank_d;
   logic [17:0]            addr_q, addr_d;
   logic                   dat_oe_q, dat_oe_d;
   logic                   cs_n_q, cs_n_d;
   logic                   oe_n_q, oe_n_d;
   logic                   we_n_q, we_n_d;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      we_d     = we_q;
      ack_d    = 1'b0;
      dat_d    = dat_q;
      wdat_d   = wdat_q;
      bank_d   = i_bank_we ? i_bank : bank_q;
      addr_d   = addr_q;
      dat_oe_d = dat_oe_q;
      cs_n_d   = cs_n_q;
      oe_n_d   = oe_n_q;
      we_n_d   = we_n_q;
      case (state_q)
         IDLE: if (i_cs) begin
            state_d  = SETUP;
            we_d     = i_we;
            wdat_d   = i_dat;
            // the banked window uses the bank value from before this edge
            addr_d   = (i_addr < 16'hC000) ? {2'b00, i_addr} : 18'({bank_q, i_addr[13:0]});
            cs_n_d   = 1'b0;
            oe_n_d   = i_we;
            dat_oe_d = i_we;
            we_n_d   = 1'b1;
         end
         SETUP: begin
            state_d = ACCESS;
            cnt_d   = 4'(WAIT_CYCLES);
            we_n_d  = ~we_q;
         end
         ACCESS: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd0) begin
               state_d = ACK;
               cnt_d   = cnt_q;
               ack_d   = 1'b1;
               dat_d   = we_q ? dat_q : i_sram_dat;
               we_n_d  = 1'b1;
            end
         end
         ACK: begin
            state_d  = i_cs ? RELEASE : IDLE;
            cs_n_d   = 1'b1;
            oe_n_d   = 1'b1;
            dat_oe_d = 1'b0;
         end
         RELEASE: state_d = i_cs ? RELEASE : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         we_q     <= 1'b0;
         ack_q    <= 1'b0;
         dat_q    <= '0;
         wdat_q   <= '0;
         bank_q   <= '0;
         addr_q   <= '0;
         dat_oe_q <= 1'b0;
         cs_n_q   <= 1'b1;
         oe_n_q   <= 1'b1;
         we_n_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         we_q     <= we_d;
         ack_q    <= ack_d;
         dat_q    <= dat_d;
         wdat_q   <= wdat_d;
         bank_q   <= bank_d;
         addr_q   <= addr_d;
         dat_oe_q <= dat_oe_d;
         cs_n_q   <= cs_n_d;
         oe_n_q   <= oe_n_d;
         we_n_q   <= we_n_d;
      end
   end

   assign o_dat         = dat_q;
   assign o_ack         = ack_q;
   assign o_bank        = bank_q;
   assign o_sram_addr   = addr_q;
   assign o_sram_dat    = wdat_q;
   assign o_sram_dat_oe = dat_oe_q;
   assign o_sram_cs_n   = cs_n_q;
   assign o_sram_oe_n   = oe_n_q;
   assign o_sram_we_n   = we_n_q;
endmodule

// File: tb/tb_sram_bridge.sv
// tb_sram_bridge: directed checks of the SRAM bridge against a behavioural SRAM model.
module tb_sram_bridge;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, we, cs, bank_we;
   logic [15:0] addr;
   logic [7:0]  wdat, sram_rd, o_dat, sram_wdat;
   logic [3:0]  bank_in, bank;
   logic [17:0] sram_addr;
   logic        ack, dat_oe, cs_n, oe_n, we_n;
   logic [7:0]  mem [0:262143];

   logic        cs_s;
   logic [7:0]  dat0, dat15, sd0, sd15;
   logic [3:0]  bk0, bk15;
   logic [17:0] sa0, sa15;
   logic        ack0, ack15, doe0, doe15, csn0, csn15, oen0, oen15, wen0, wen15;

   int checks = 0, failures = 0;
   int ack_cnt = 0, acc_cnt = 0;
   logic prev_ack = 1'b0, prev_cs_n = 1'b1;
   logic [15:0] ack_b, wel_b, csl_b, doe_b, oel_b;
   logic [17:0] addr1;
   logic [7:0]  dat4;

   sram_bridge #(.WAIT_CYCLES(1), .BANK_BITS(4)) dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_addr(addr), .i_dat(wdat), .o_dat(o_dat),
      .i_we(we), .i_cs(cs), .o_ack(ack), .i_bank_we(bank_we), .i_bank(bank_in),
      .o_bank(bank), .o_sram_addr(sram_addr), .o_sram_dat(sram_wdat),
      .o_sram_dat_oe(dat_oe), .i_sram_dat(sram_rd), .o_sram_cs_n(cs_n),
      .o_sram_oe_n(oe_n), .o_sram_we_n(we_n));

   sram_bridge #(.WAIT_CYCLES(0), .BANK_BITS(4)) dut0 (
      .i_clk(clk), .i_reset_n(rst_n), .i_addr(16'h0010), .i_dat(8'h00), .o_dat(dat0),
      .i_we(1'b0), .i_cs(cs_s), .o_ack(ack0), .i_bank_we(1'b0), .i_bank(4'h0),
      .o_bank(bk0), .o_sram_addr(sa0), .o_sram_dat(sd0), .o_sram_dat_oe(doe0),
      .i_sram_dat(8'h5A), .o_sram_cs_n(csn0), .o_sram_oe_n(oen0), .o_sram_we_n(wen0));

   sram_bridge #(.WAIT_CYCLES(15), .BANK_BITS(4)) dut15 (
      .i_clk(clk), .i_reset_n(rst_n), .i_addr(16'h0010), .i_dat(8'h00), .o_dat(dat15),
      .i_we(1'b0), .i_cs(cs_s), .o_ack(ack15), .i_bank_we(1'b0), .i_bank(4'h0),
      .o_bank(bk15), .o_sram_addr(sa15), .o_sram_dat(sd15), .o_sram_dat_oe(doe15),
      .i_sram_dat(8'hC3), .o_sram_cs_n(csn15), .o_sram_oe_n(oen15), .o_sram_we_n(wen15));

   assign sram_rd = (!cs_n && !oe_n) ? mem[sram_addr] : 8'hEE;

   // preload happens while reset is held so the array has a single writer
   always @(posedge clk) begin
      if (!rst_n) begin
         mem[18'h01234] <= 8'hA5;
         mem[18'h24005] <= 8'h77;
         mem[18'h24000] <= 8'h42;
         mem[18'h00100] <= 8'h00;
      end else if (!cs_n && !we_n)
         mem[sram_addr] <= sram_wdat;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      check("no_contention", 32'(dat_oe & ~oe_n), 32'h0);
      check("ack_single", 32'(ack & prev_ack), 32'h0);
      if (ack) ack_cnt++;
      if (prev_cs_n && !cs_n) acc_cnt++;
      prev_ack  = ack;
      prev_cs_n = cs_n;
   end

   task automatic access(input logic w, input logic [15:0] a, input logic [7:0] d, input bit hold);
      we = w; addr = a; wdat = d; cs = 1'b1;
      ack_b = '0; wel_b = '0; csl_b = '0; doe_b = '0; oel_b = '0;
      for (int c = 1; c < 16; c++) begin
         @(negedge clk);
         bank_we = 1'b0;
         ack_b[c] = ack; wel_b[c] = ~we_n; csl_b[c] = ~cs_n; doe_b[c] = dat_oe; oel_b[c] = ~oe_n;
         if (c == 1) begin
            addr1 = sram_addr;
            we = ~w; addr = ~a; wdat = ~d;
         end
         if (c == 4) dat4 = o_dat;
         if (ack && !hold) cs = 1'b0;
      end
   endtask

   initial begin
      int a0, a1, l0, l15;
      rst_n = 1'b0; we = 1'b0; cs = 1'b0; bank_we = 1'b0; bank_in = 4'h0;
      addr = '0; wdat = '0; cs_s = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ack", 32'(ack), 32'h0);
      check("rst_dat", 32'(o_dat), 32'h0);
      check("rst_bank", 32'(bank), 32'h0);
      check("rst_addr", 32'(sram_addr), 32'h0);
      check("rst_wdat", 32'(sram_wdat), 32'h0);
      check("rst_strobes", {28'h0, dat_oe, cs_n, oe_n, we_n}, 32'h7);
      rst_n = 1'b1;
      @(negedge clk);

      access(1'b0, 16'h1234, 8'h00, 1'b0);
      check("rd_addr", 32'(addr1), 32'h01234);
      check("rd_oe_low", 32'(oel_b), 32'h001E);
      check("rd_ack", 32'(ack_b), 32'h0010);
      check("rd_dat4", 32'(dat4), 32'hA5);
      check("rd_dat_held", 32'(o_dat), 32'hA5);
      check("rd_no_drive", 32'(doe_b), 32'h0);

      access(1'b1, 16'h0100, 8'h3C, 1'b0);
      check("wr_addr", 32'(addr1), 32'h00100);
      check("wr_we_low", 32'(wel_b), 32'h000C);
      check("wr_dat_oe", 32'(doe_b), 32'h001E);
      check("wr_cs_low", 32'(csl_b), 32'h001E);
      check("wr_oe_high", 32'(oel_b), 32'h0);
      check("wr_ack", 32'(ack_b), 32'h0010);
      check("wr_mem", 32'(mem[18'h00100]), 32'h3C);
      check("wr_dat_keep", 32'(o_dat), 32'hA5);

      bank_we = 1'b1; bank_in = 4'h9;
      @(negedge clk);
      bank_we = 1'b0;
      check("bank_load", 32'(bank), 32'h9);
      access(1'b0, 16'hC005, 8'h00, 1'b0);
      check("bank_addr", 32'(addr1), 32'h24005);
      check("bank_dat", 32'(o_dat), 32'h77);

      bank_we = 1'b1; bank_in = 4'h2;
      @(negedge clk);
      bank_in = 4'h9;
      access(1'b0, 16'hFFFF, 8'h00, 1'b0);
      check("bank_same_edge", 32'(addr1), 32'h0BFFF);
      check("bank_new", 32'(bank), 32'h9);
      access(1'b0, 16'hC000, 8'h00, 1'b0);
      check("bank_next", 32'(addr1), 32'h24000);
      check("bank_next_dat", 32'(o_dat), 32'h42);

      a0 = ack_cnt; a1 = acc_cnt;
      access(1'b0, 16'h1234, 8'h00, 1'b1);
      repeat (10) @(negedge clk);
      check("held_acks", 32'(ack_cnt - a0), 32'h1);
      check("held_accesses", 32'(acc_cnt - a1), 32'h1);
      cs = 1'b0;
      @(negedge clk);
      access(1'b0, 16'h1234, 8'h00, 1'b0);
      check("b2b_ack", 32'(ack_b), 32'h0010);

      a0 = ack_cnt;
      we = 1'b1; addr = 16'h0200; wdat = 8'h11; cs = 1'b1;
      repeat (2) @(negedge clk);
      check("mid_we_low", 32'(we_n), 32'h0);
      rst_n = 1'b0; cs = 1'b0;
      @(negedge clk);
      check("abort_strobes", {28'h0, dat_oe, cs_n, oe_n, we_n}, 32'h7);
      check("abort_ack", 32'(ack), 32'h0);
      check("abort_bank", 32'(bank), 32'h0);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check("abort_no_ack", 32'(ack_cnt - a0), 32'h0);

      l0 = 0; l15 = 0;
      cs_s = 1'b1;
      for (int c = 1; c < 40; c++) begin
         @(negedge clk);
         if (ack0 && l0 == 0) l0 = c;
         if (ack15 && l15 == 0) l15 = c;
      end
      cs_s = 1'b0;
      check("lat_w0", 32'(l0), 32'd3);
      check("lat_w15", 32'(l15), 32'd18);
      check("w0_dat", 32'(dat0), 32'h5A);
      check("w15_dat", 32'(dat15), 32'hC3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
